// File: rtl/fpu_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : fpu_pkg                                                          |
// | Purpose  : Shared types, constants and datapath helpers for the integer-    |
// |            to-binary32 converter (rounding modes, field widths, the         |
// |            normalise and round/pack steps).                                 |
// | Ports    : none (package)                                                   |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package fpu_pkg;

  // binary32 field layout and exponent bias
  localparam int FLOAT_BIAS = 127;
  localparam int SIGN_W     = 1;
  localparam int EXP_W      = 8;
  localparam int MANT_W     = 23;
  localparam int BIN32_W    = SIGN_W + EXP_W + MANT_W;

  // integer operand width and leading-zero count width
  localparam int INT_W      = 32;
  localparam int LZC_W      = 6;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,  // round to nearest, ties to even
    RM_RTZ = 2'b01,  // toward zero
    RM_RDN = 2'b10,  // toward -inf
    RM_RUP = 2'b11   // toward +inf
  } rm_e;

  // After sign removal and leading-zero count
  typedef struct packed {
    logic             sign;
    logic [INT_W-1:0] mag;
    logic [LZC_W-1:0] lzc;
    rm_e              rm;
  } abs_t;

  // After normalisation: unrounded mantissa plus rounding bits
  typedef struct packed {
    logic              sign;
    logic              zero;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              guard;
    logic              sticky;
    rm_e               rm;
  } norm_t;

  // Packed result
  typedef struct packed {
    logic [BIN32_W-1:0] y;
    logic               inexact;
  } res_t;

  // Shift the leading one up to bit 31; the 23 bits below it form the
  // mantissa, the next bit is guard and the rest fold into sticky.
  // A zero magnitude is the only case with no leading one after the shift.
  function automatic norm_t normalise(abs_t a);
    norm_t            n;
    logic [INT_W-1:0] sh;
    sh       = a.mag << a.lzc;
    n.sign   = a.sign;
    n.zero   = ~sh[INT_W-1];
    n.exp    = EXP_W'(FLOAT_BIAS + INT_W - 1 - int'(a.lzc));
    n.mant   = sh[INT_W-2 -: MANT_W];
    n.guard  = sh[INT_W-2-MANT_W];
    n.sticky = |sh[INT_W-3-MANT_W:0];
    n.rm     = a.rm;
    return n;
  endfunction

  // Apply the rounding decision; a mantissa carry-out bumps the exponent and
  // leaves the mantissa field at zero. The exponent tops out at 159, so no
  // overflow path is needed.
  function automatic res_t round_pack(norm_t n);
    res_t              r;
    logic              up;
    logic [MANT_W:0]   sum;
    logic [EXP_W-1:0]  e;
    r.inexact = n.guard | n.sticky;
    up        = 1'b0;
    case (n.rm)
      RM_RNE:  up = n.guard & (n.sticky | n.mant[0]);
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = r.inexact & n.sign;
      RM_RUP:  up = r.inexact & ~n.sign;
      default: up = 1'b0;
    endcase
    sum = {1'b0, n.mant} + {{MANT_W{1'b0}}, up};
    e   = n.exp + {{(EXP_W-1){1'b0}}, sum[MANT_W]};
    r.y = n.zero ? '0 : {n.sign, e, sum[MANT_W-1:0]};
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lzc32.sv
// +----------------------------------------------------------------------------+
// | Module   : lzc32                                                            |
// | Purpose  : Combinational 32-bit leading-zero counter.                       |
// | Ports    : a_i   [31:0] in  - value to scan                                 |
// |            cnt_o [5:0]  out - number of leading zeros (32 when a_i == 0)    |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module lzc32 (
  input  logic [31:0] a_i,
  output logic [5:0]  cnt_o
);

  // Scan upward; the highest set bit is the last one to write the count.
  always_comb begin
    cnt_o = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (a_i[i]) begin
        cnt_o = 6'(31 - i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/itof_pipe.sv
// +----------------------------------------------------------------------------+
// | Module   : itof_pipe                                                        |
// | Purpose  : Pipelined 32-bit integer (signed/unsigned) to IEEE-754 binary32  |
// |            converter with four rounding modes and a valid/ready stream on   |
// |            both sides. NSTAGE (1..3) register stages, no skid storage.      |
// | Ports    : clk, rstn            - clock, async active-low reset             |
// |            in_valid/in_ready    - input handshake                           |
// |            x, is_unsigned, rm   - operand, signedness, rounding mode        |
// |            in_tag / out_tag     - sideband tag carried with the operand     |
// |            out_valid/out_ready  - output handshake                          |
// |            y, inexact           - binary32 result and inexact flag          |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module itof_pipe
  import fpu_pkg::*;
#(
  parameter int NSTAGE = 2,
  parameter int TAGW   = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     x,
  input  logic            is_unsigned,
  input  logic [1:0]      rm,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     y,
  output logic            inexact,
  output logic [TAGW-1:0] out_tag
);

  // --------------------------------------------------------------------------
  // Front end: sign removal and leading-zero count on the incoming operand
  // --------------------------------------------------------------------------
  logic        in_sign;
  logic [31:0] in_mag;
  logic [5:0]  in_lzc;
  abs_t        s0_d;

  assign in_sign = ~is_unsigned & x[31];
  // Two's-complement negate; 0x80000000 maps onto itself, i.e. 2^31.
  assign in_mag  = in_sign ? (~x + 32'd1) : x;

  lzc32 u_lzc (
    .a_i   (in_mag),
    .cnt_o (in_lzc)
  );

  assign s0_d = '{sign: in_sign, mag: in_mag, lzc: in_lzc, rm: rm_e'(rm)};

  // --------------------------------------------------------------------------
  // Stage control: one valid bit and tag per stage
  // --------------------------------------------------------------------------
  logic [NSTAGE-1:0] stage_valid;
  logic [NSTAGE-1:0] stage_load;
  logic [TAGW-1:0]   stage_tag [NSTAGE];

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic            valid_q;
    logic [TAGW-1:0] tag_q;
    logic            src_valid;
    logic [TAGW-1:0] src_tag;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_tag   = in_tag;
    end else begin : g_body
      assign src_valid = stage_valid[k-1];
      assign src_tag   = stage_tag[k-1];
    end

    // A stage may load unless it and every stage after it are full while the
    // consumer is stalled. Written as a reduction rather than a ripple so the
    // enables depend on registers and out_ready only.
    assign stage_load[k] = out_ready | ~(&stage_valid[NSTAGE-1:k]);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        valid_q <= 1'b0;
        tag_q   <= '0;
      end else if (stage_load[k]) begin
        valid_q <= src_valid;
        if (src_valid) begin
          tag_q <= src_tag;
        end
      end
    end

    assign stage_valid[k] = valid_q;
    assign stage_tag[k]   = tag_q;
  end

  // --------------------------------------------------------------------------
  // Datapath registers; placement of the cut points depends on NSTAGE.
  // Data registers only load when a valid operand enters them so that the
  // held result never changes while stalled.
  // --------------------------------------------------------------------------
  res_t res_q;

  if (NSTAGE == 1) begin : g_ns1
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        res_q <= '0;
      end else if (stage_load[0] && in_valid) begin
        res_q <= round_pack(normalise(s0_d));
      end
    end
  end else if (NSTAGE == 2) begin : g_ns2
    abs_t s1_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        s1_q  <= '0;
        res_q <= '0;
      end else begin
        if (stage_load[0] && in_valid) begin
          s1_q <= s0_d;
        end
        if (stage_load[1] && stage_valid[0]) begin
          res_q <= round_pack(normalise(s1_q));
        end
      end
    end
  end else begin : g_ns3
    abs_t  s1_q;
    norm_t s2_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        s1_q  <= '0;
        s2_q  <= '0;
        res_q <= '0;
      end else begin
        if (stage_load[0] && in_valid) begin
          s1_q <= s0_d;
        end
        if (stage_load[1] && stage_valid[0]) begin
          s2_q <= normalise(s1_q);
        end
        if (stage_load[2] && stage_valid[1]) begin
          res_q <= round_pack(s2_q);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready  = stage_load[0];
  assign out_valid = stage_valid[NSTAGE-1];
  assign out_tag   = stage_tag[NSTAGE-1];
  assign y         = res_q.y;
  assign inexact   = res_q.inexact;

endmodule

`default_nettype wire

// File: tb/tb_itof_pipe.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_itof_pipe                                                     |
// | Purpose  : Self-checking bench for itof_pipe: arithmetic reference model,   |
// |            scoreboard queue, stall/stability checks, directed vectors,      |
// |            random stream with random back-pressure, reset flush.           |
// | Ports    : none                                                             |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_itof_pipe;

  localparam int NSTAGE = 2;
  localparam int TAGW   = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     x;
  logic            is_unsigned;
  logic [1:0]      rm;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     y;
  logic            inexact;
  logic [TAGW-1:0] out_tag;

  itof_pipe #(.NSTAGE(NSTAGE), .TAGW(TAGW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .is_unsigned (is_unsigned),
    .rm          (rm),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y           (y),
    .inexact     (inexact),
    .out_tag     (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     y;
    logic            inx;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rand_ready = 1'b0;

  bit              hold_v = 1'b0;
  logic [31:0]     hold_y;
  logic            hold_inx;
  logic [TAGW-1:0] hold_tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: exact magnitude, find the top bit, divide down to 24
  // significant bits and round from the remainder against one half ulp.
  function automatic logic [32:0] ref_cvt(input logic [31:0] xv, input logic uns,
                                          input logic [1:0] m);
    bit              neg;
    bit              inx;
    bit              up;
    longint unsigned v, q, rem, half;
    int              e, sh;
    neg = !uns && xv[31];
    v   = neg ? (64'd4294967296 - 64'(xv)) : 64'(xv);
    if (v == 0) return 33'd0;
    e = 0;
    for (int i = 0; i < 33; i++) if (v[i]) e = i;
    if (e <= 23) begin
      q    = v << (23 - e);
      rem  = 0;
      half = 0;
    end else begin
      sh   = e - 23;
      q    = v >> sh;
      rem  = v - (q << sh);
      half = 64'd1 << (sh - 1);
    end
    inx = (rem != 0);
    case (m)
      2'd0:    up = inx && ((rem > half) || (rem == half && q[0]));
      2'd1:    up = 1'b0;
      2'd2:    up = inx && neg;
      default: up = inx && !neg;
    endcase
    q = q + 64'(up);
    if (q == 64'd16777216) begin
      q = q >> 1;
      e = e + 1;
    end
    return {inx, neg, 8'(e + 127), 23'(q)};
  endfunction

  // Monitor/scoreboard: inputs and outputs are stable at the falling edge, so
  // transfers that the next rising edge will perform are decided here.
  always @(negedge clk) begin
    exp_t        e;
    logic [32:0] r;
    if (rstn !== 1'b1) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_y", y, hold_y);
        chk("stall_inexact", {31'd0, inexact}, {31'd0, hold_inx});
        chk("stall_tag", 32'(out_tag), 32'(hold_tag));
      end
      hold_v   = out_valid && !out_ready;
      hold_y   = y;
      hold_inx = inexact;
      hold_tag = out_tag;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got y=0x%08h tag=%0d, expected no result", y, out_tag);
        end else begin
          e = exp_q.pop_front();
          chk("y", y, e.y);
          chk("inexact", {31'd0, inexact}, {31'd0, e.inx});
          chk("tag", 32'(out_tag), 32'(e.tag));
        end
      end
      if (in_valid && in_ready) begin
        r = ref_cvt(x, is_unsigned, rm);
        exp_q.push_back('{y: r[31:0], inx: r[32], tag: in_tag});
      end
    end
  end

  // Random back-pressure during the stream phase
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // All driving tasks start and end just after a rising edge.
  task automatic send(input logic [31:0] xv, input logic uns, input logic [1:0] m,
                      input logic [TAGW-1:0] t);
    int n;
    in_valid    = 1'b1;
    x           = xv;
    is_unsigned = uns;
    rm          = m;
    in_tag      = t;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, expected acceptance", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Directed vectors with hand-computed results
  localparam int NPIN = 17;
  logic [31:0] pin_x   [NPIN] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h01000001,
                                  32'h01000003, 32'hFEFFFFFF, 32'hFEFFFFFF, 32'h00000000,
                                  32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF,
                                  32'h00000001, 32'h01000001, 32'h01000001, 32'h00FFFFFF,
                                  32'h7FFFFFFF};
  logic        pin_u   [NPIN] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [1:0]  pin_rm  [NPIN] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1,
                                  2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [31:0] pin_y   [NPIN] = '{32'hCF000000, 32'h4F800000, 32'h4F7FFFFF, 32'h4B800000,
                                  32'h4B800002, 32'hCB800001, 32'hCB800000, 32'h00000000,
                                  32'h00000000, 32'h00000000, 32'h00000000, 32'hBF800000,
                                  32'h3F800000, 32'h4B800000, 32'h4B800001, 32'h4B7FFFFF,
                                  32'h4EFFFFFF};
  logic        pin_inx [NPIN] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int          n;
    int          acc;
    int          cnt;
    logic [32:0] r;
    logic [31:0] xv;

    rstn        = 1'b1;
    in_valid    = 1'b0;
    x           = '0;
    is_unsigned = 1'b0;
    rm          = 2'd0;
    in_tag      = '0;
    out_ready   = 1'b0;

    // Reset state
    #2 rstn = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_inexact", {31'd0, inexact}, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Latency from an empty pipeline, with a literal result check
    out_ready = 1'b1;
    send(32'hFFFFFFFF, 1'b0, 2'd0, 4'd9);
    n = 1;
    while (n <= 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(NSTAGE));
    chk("lat_y", y, 32'hBF800000);
    chk("lat_inexact", {31'd0, inexact}, 32'd0);
    chk("lat_tag", 32'(out_tag), 32'd9);
    @(posedge clk);
    #1;

    // Pin the model to literals, then stream the same vectors through the DUT
    for (int i = 0; i < NPIN; i++) begin
      r = ref_cvt(pin_x[i], pin_u[i], pin_rm[i]);
      chk($sformatf("model_y[%0d]", i), r[31:0], pin_y[i]);
      chk($sformatf("model_inexact[%0d]", i), {31'd0, r[32]}, {31'd0, pin_inx[i]});
      send(pin_x[i], pin_u[i], pin_rm[i], 4'(i));
    end
    drain("pins_drained");

    // Fill with the consumer stalled, then release for full-rate drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      x           = 32'h00012345 + 32'(i * 977);
      is_unsigned = 1'b0;
      rm          = 2'(i);
      in_tag      = 4'(i + 3);
      @(negedge clk);
      if (!in_ready) break;
      acc++;
      @(posedge clk);
      #1;
    end
    chk("fill_accepts", 32'(acc), 32'(NSTAGE));
    repeat (3) @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < NSTAGE; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
      @(posedge clk);
      #1;
    end
    chk("release_rate", 32'(cnt), 32'(NSTAGE));
    drain("fill_drained");

    // Random stream with random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0: xv = $urandom;
        1: xv = 32'($urandom_range(0, 40));
        2: begin
          xv = 32'd1 << $urandom_range(0, 31);
          xv = xv + 32'($urandom_range(0, 2)) - 32'd1;
        end
        default: xv = 32'd0 - 32'($urandom_range(0, 3000));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(xv, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'(i % 16));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    drain("stream_drained");

    // Reset with operands in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x = 32'h00001234; is_unsigned = 1'b0; rm = 2'd0; in_tag = 4'd5;
    @(posedge clk);
    #1;
    x = 32'hFFFF0000; in_tag = 4'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_y", y, 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("flush_no_stale", 32'(cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1000000, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/itof_pipe.md
ITOF_PIPE -- requirements
Module: itof_pipe

Interface
REQ-001 Parameter NSTAGE, default 2, number of pipeline register stages (legal 1..3).
REQ-002 Parameter TAGW, default 4, width of the sideband tag carried alongside each operand.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand present on x this cycle.
REQ-006 in_ready  output  1  pipeline accepts operand this cycle.
REQ-007 x  input  32  integer operand.
REQ-008 is_unsigned  input  1  1: x is unsigned; 0: x is two's complement.
REQ-009 rm  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf).
REQ-010 in_tag  input  TAGW  sideband tag, returned unchanged with the result.
REQ-011 out_valid  output  1  result present on y.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 y  output  32  IEEE-754 binary32 result.
REQ-014 inexact  output  1  result differs from the exact integer value.
REQ-015 out_tag  output  TAGW  tag of the operand producing y.

Function
REQ-016 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-017 Each stage holds a valid bit; a stage loads when it is empty or its contents advance in the same cycle.
REQ-018 in_ready = stage-1 empty OR stage 1 advancing; full throughput of one result per cycle with out_ready held high.
REQ-019 Latency, accept to out_valid, is exactly NSTAGE cycles when not stalled.
REQ-020 While out_ready is low and out_valid high, y, inexact, out_tag stay stable and no accepted operand is lost or duplicated.
REQ-021 is_unsigned, rm, in_tag are captured with x and travel with it; later changes do not affect in-flight operands.
REQ-022 Stage split: NSTAGE=1 all logic before one register; NSTAGE=2 abs+leading-zero count | normalise+round; NSTAGE=3 abs+LZC | normalise | round+pack.
REQ-023 Sign = x[31] if signed, else 0; magnitude = |x| as 32-bit unsigned (signed 0x80000000 gives magnitude 2^31).
REQ-024 Exponent = 127 + (31 - lzc); mantissa = 23 bits below leading one; guard/sticky from remaining bits.
REQ-025 RNE: round up if guard && (sticky || lsb); RTZ: truncate; RDN: round magnitude up if inexact && sign; RUP: round magnitude up if inexact && !sign.
REQ-026 Mantissa carry-out on rounding increments exponent and clears mantissa (e.g. 2^32 = 0x4F800000).
REQ-027 x = 0 gives y = 0x00000000 (+0.0) in every mode, inexact = 0.
REQ-028 inexact = guard || sticky; no overflow, underflow or NaN is ever produced.
REQ-029 Simultaneous out-transfer and in-transfer on a full pipeline both succeed in that cycle.

Reset
REQ-030 On rstn low all valid bits clear immediately; out_valid = 0, y = 0, inexact = 0, out_tag = 0.
REQ-031 in_ready = 1 from the first clock edge after rstn rises.
REQ-032 Reset mid-operation discards all in-flight operands; no result for them ever appears.

Structure
REQ-033 Package fpu_pkg holds the rounding-mode enum, FLOAT_BIAS = 127, and binary32 field widths (1/8/23).
REQ-034 Leading-zero count is a separate sub-module lzc32 (32-bit in, 6-bit count, combinational).
REQ-035 The pipeline holds no storage beyond NSTAGE stage registers; no skid buffer.

Verification
REQ-036 Signed x=0xFFFFFFFF (-1), RNE -> y=0xBF800000, inexact=0, after NSTAGE cycles.
REQ-037 Signed x=0x80000000 -> y=0xCF000000 inexact=0; unsigned x=0xFFFFFFFF RNE -> 0x4F800000 inexact=1, RTZ -> 0x4F7FFFFF inexact=1.
REQ-038 Signed x=0x01000001 RNE -> 0x4B800000 (tie to even); x=0x01000003 RNE -> 0x4B800002; x=0xFEFFFFFF RDN -> 0xCB800001, RUP -> 0xCB800000.
REQ-039 Stream 1000 random operands with tags 0..15, out_ready toggled randomly -> every result matches a round-correct reference model, in order, tags intact, none dropped.
REQ-040 Fill pipeline with out_ready=0 -> in_ready falls after NSTAGE accepts, y held stable; release -> one result per cycle.
REQ-041 Assert rstn low with 2 operands in flight -> out_valid=0 at once; after release no stale result appears.
